fp_div_sqrt_requester: RTL
==========================

FP_DIV_SQRT_REQUESTER -- requirements
Module: fp_div_sqrt_requester

Interface
REQ-001 The block SHALL have parameter AL_INDEX_WIDTH, default 6, giving the active-list pointer width.
REQ-002 The block SHALL have parameter BUSY_TIMEOUT, default 64, giving the number of BUSY cycles before a timeout error is flagged.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- issue_valid  in  1  issue stage presents a div/sqrt op.
- issue_ready  out  1  op accepted this cycle.
- issue_is_divide  in  1  1 = divide, 0 = sqrt.
- issue_opa, issue_opb  in  32  FP32 operands (opb ignored for sqrt).
- issue_al_ptr  in  AL_INDEX_WIDTH  active-list index of the op.
- div_free  in  1  unit Free.
- div_finished  in  1  unit Finished (level).
- div_result  in  32  unit DataOut.
- div_acquire  out  1  unit Acquire.
- div_acquire_ptr  out  AL_INDEX_WIDTH  unit acquireActiveListPtr.
- div_req  out  1  unit Req.
- div_is_divide  out  1  unit is_divide.
- div_opa, div_opb  out  32  unit dataInA / dataInB.
- div_release  out  1  unit Release.
- flush_valid  in  1  recovery flush this cycle.
- flush_all  in  1  flush every op.
- flush_head, flush_tail  in  AL_INDEX_WIDTH  flush range (head inclusive, tail exclusive).
- wb_valid  out  1  result ready for writeback.
- wb_ready  in  1  writeback accepted.
- wb_data  out  32  result.
- wb_al_ptr  out  AL_INDEX_WIDTH  pointer of result.
- timeout_err  out  1  sticky BUSY-timeout flag.

Function
REQ-005 The block SHALL implement the four states IDLE, RESERVED, BUSY and RESULT.
REQ-006 issue_ready SHALL equal state==IDLE && div_free && !flush_valid.
REQ-007 In IDLE, when issue_valid && issue_ready, the block SHALL pulse div_acquire=1 with div_acquire_ptr=issue_al_ptr, latch the operands, is_divide and pointer, and go to RESERVED.
REQ-008 RESERVED SHALL last exactly one cycle, with div_req=1 and div_opa/div_opb/div_is_divide driven from the latches, and then go to BUSY.
REQ-009 div_opa, div_opb and div_is_divide SHALL be held stable from RESERVED until the block returns to IDLE.
REQ-010 In BUSY, the block SHALL wait for div_finished=1, then capture div_result into wb_data and go to RESULT.
REQ-011 In RESULT, wb_valid SHALL be 1 with wb_al_ptr equal to the latched pointer.
REQ-012 In RESULT, on wb_ready=1 the block SHALL assert div_release=1 for that cycle and return to IDLE.
REQ-013 In RESULT, wb_data and wb_al_ptr SHALL hold stable while wb_ready=0.
REQ-014 Issue-to-wb_valid latency SHALL be 2 cycles plus the number of BUSY cycles.
REQ-015 Flush hit: when state!=IDLE and flush_valid=1, the latched pointer p SHALL be treated as hit if flush_all=1, or if head<tail and head<=p<tail, or if head>tail and (p>=head or p<tail); head==tail with flush_all=0 SHALL be treated as an empty range.
REQ-016 On a flush hit, the block SHALL go to IDLE in the next cycle.
REQ-017 On a flush hit, wb_valid and div_release SHALL be forced to 0 in that cycle, because the unit frees itself.
REQ-018 On a flush hit, div_req SHALL be forced to 0 in that cycle.
REQ-019 A flush that misses SHALL have no effect.
REQ-020 The block SHALL count consecutive cycles in BUSY with a counter that clears on leaving BUSY.
REQ-021 When the BUSY counter reaches BUSY_TIMEOUT, timeout_err SHALL set and stay set until reset.
REQ-022 The BUSY counter SHALL saturate and not wrap.
REQ-023 The outputs div_acquire, div_req and div_release SHALL never be asserted in the same cycle as each other.

Reset
REQ-024 While rst_n=0 at a clock edge, the state SHALL go to IDLE, all latches and the counter SHALL clear to 0, and timeout_err SHALL clear.
REQ-025 While in reset, every output SHALL be 0, except issue_ready, which SHALL follow REQ-006.
REQ-026 Reset asserted in any state SHALL abandon the op with no div_release.

Verification
REQ-027 Divide: issue 0x40C00000 / 0x40000000 with ptr=5; unit finishes after 10 BUSY cycles -> acquire at T0, req at T1, wb_valid at T12, wb_data=0x40400000, wb_al_ptr=5, release when wb_ready=1.
REQ-028 Sqrt: issue_is_divide=0, opa=0x41100000 -> div_is_divide=0, wb_data=0x40400000.
REQ-029 Backpressure: hold wb_ready=0 for 5 cycles in RESULT -> wb_valid and wb_data stable, no release; wb_ready=1 -> one-cycle release, then IDLE.
REQ-030 Wrap-around flush: ptr=1 in BUSY, flush head=60, tail=2 -> IDLE next cycle, no wb_valid and no release; repeat with ptr=10 -> unaffected.
REQ-031 Timeout: hold div_finished=0 for 64 BUSY cycles -> timeout_err=1 and stays 1.
REQ-032 Reset mid-BUSY: rst_n=0 for 1 cycle -> IDLE, all outputs 0, issue_ready follows div_free.
REQ-033 Issue during flush: issue_valid=1, div_free=1 and flush_valid=1 -> issue_ready=0 and no acquire.

Source files
------------

// File: rtl/fp_div_sqrt_requester.sv
// -----------------------------------------------------------------------------
// fp_div_sqrt_requester
//
// Issue-side requester for a shared FP32 divide / square-root unit. It accepts
// one op from the issue stage, reserves the unit (Acquire), presents the
// operands (Req), waits for the unit to finish, hands the result to writeback
// and then releases the unit. A recovery flush that covers the op's
// active-list pointer abandons it; the unit frees itself in that case, so no
// Release is sent.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   issue_*                    op from the issue stage (valid/ready handshake)
//   div_free/finished/result   status and data from the div/sqrt unit
//   div_acquire(_ptr)          reserve the unit for the op's pointer
//   div_req, div_is_divide,
//   div_opa, div_opb           start request and operands to the unit
//   div_release                give the unit back after writeback
//   flush_*                    recovery flush (all, or [head, tail) ring range)
//   wb_*                       result to writeback (valid/ready handshake)
//   timeout_err                sticky flag: unit stayed busy too long
// -----------------------------------------------------------------------------
module fp_div_sqrt_requester #(
    parameter int AL_INDEX_WIDTH = 6,
    parameter int BUSY_TIMEOUT   = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic                      issue_is_divide,
    input  logic [31:0]               issue_opa,
    input  logic [31:0]               issue_opb,
    input  logic [AL_INDEX_WIDTH-1:0] issue_al_ptr,
    input  logic                      div_free,
    input  logic                      div_finished,
    input  logic [31:0]               div_result,
    output logic                      div_acquire,
    output logic [AL_INDEX_WIDTH-1:0] div_acquire_ptr,
    output logic                      div_req,
    output logic                      div_is_divide,
    output logic [31:0]               div_opa,
    output logic [31:0]               div_opb,
    output logic                      div_release,
    input  logic                      flush_valid,
    input  logic                      flush_all,
    input  logic [AL_INDEX_WIDTH-1:0] flush_head,
    input  logic [AL_INDEX_WIDTH-1:0] flush_tail,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [31:0]               wb_data,
    output logic [AL_INDEX_WIDTH-1:0] wb_al_ptr,
    output logic                      timeout_err
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RESERVED = 2'd1;
    localparam logic [1:0] ST_BUSY     = 2'd2;
    localparam logic [1:0] ST_RESULT   = 2'd3;

    localparam int              CNT_W   = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT);

    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic                      r_is_divide;
    logic [31:0]               r_opa;
    logic [31:0]               r_opb;
    logic [AL_INDEX_WIDTH-1:0] r_ptr;
    logic [31:0]               r_wb_data;
    logic [CNT_W-1:0]          r_busy_cnt;
    logic [CNT_W-1:0]          w_cnt_inc;
    logic                      r_timeout;
    logic                      w_in_range;
    logic                      w_flush_hit;
    logic                      w_accept;

    // Flush range is a ring segment [head, tail); head == tail is empty
    // unless flush_all is set.
    always_comb begin
        w_in_range = 1'b0;
        if (flush_head < flush_tail) begin
            w_in_range = (r_ptr >= flush_head) && (r_ptr < flush_tail);
        end else if (flush_head > flush_tail) begin
            w_in_range = (r_ptr >= flush_head) || (r_ptr < flush_tail);
        end
    end

    assign w_flush_hit = (r_state != ST_IDLE) && flush_valid && (flush_all || w_in_range);

    assign issue_ready = (r_state == ST_IDLE) && div_free && !flush_valid;
    assign w_accept    = rst_n && issue_valid && issue_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_accept)     w_state_next = ST_RESERVED;
            ST_RESERVED:                   w_state_next = ST_BUSY;
            ST_BUSY:     if (div_finished) w_state_next = ST_RESULT;
            ST_RESULT:   if (wb_ready)     w_state_next = ST_IDLE;
            default:                       w_state_next = ST_IDLE;
        endcase
        // A flushed op is dropped wherever it is; the unit frees itself.
        if (w_flush_hit) begin
            w_state_next = ST_IDLE;
        end
    end

    assign w_cnt_inc = (r_busy_cnt == CNT_MAX) ? r_busy_cnt : r_busy_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_is_divide <= 1'b0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_ptr       <= '0;
            r_wb_data   <= '0;
            r_busy_cnt  <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_is_divide <= issue_is_divide;
                r_opa       <= issue_opa;
                r_opb       <= issue_opb;
                r_ptr       <= issue_al_ptr;
            end
            if ((r_state == ST_BUSY) && div_finished && !w_flush_hit) begin
                r_wb_data <= div_result;
            end
            // The counter holds the number of BUSY cycles completed so far,
            // so the flag rises at the end of the BUSY_TIMEOUT-th cycle.
            if (r_state == ST_BUSY) begin
                r_busy_cnt <= (w_state_next == ST_BUSY) ? w_cnt_inc : '0;
                if (w_cnt_inc == CNT_MAX) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_busy_cnt <= '0;
            end
        end
    end

    // Outputs are gated by rst_n so they read 0 throughout a reset cycle,
    // including one that interrupts an op mid-flight (no Release is sent).
    assign div_acquire     = w_accept;
    assign div_acquire_ptr = w_accept ? issue_al_ptr : '0;
    assign div_req         = rst_n && (r_state == ST_RESERVED) && !w_flush_hit;
    assign div_is_divide   = rst_n && r_is_divide;
    assign div_opa         = rst_n ? r_opa : '0;
    assign div_opb         = rst_n ? r_opb : '0;
    assign div_release     = rst_n && (r_state == ST_RESULT) && wb_ready && !w_flush_hit;
    assign wb_valid        = rst_n && (r_state == ST_RESULT) && !w_flush_hit;
    assign wb_data         = rst_n ? r_wb_data : '0;
    assign wb_al_ptr       = rst_n ? r_ptr : '0;
    assign timeout_err     = rst_n && r_timeout;

endmodule
